// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : UART transmitter that pops words from a show-ahead FIFO and
//            serialises them as start / data (LSB first) / parity / stop bits.
// Revision : 1.0
// ============================================================================
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  sclr_n,
    input  logic                  tx_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH) : 3;

    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_PRE   = CNT_W'(CLK_DIV - 2);
    localparam logic [IDX_W-1:0] C_DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] C_STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             C_ODD       = (PARITY_ODD != 0);
    localparam logic             C_PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_txd;
    logic                  r_busy;
    logic                  r_done;

    logic w_fetch;
    logic w_bit_end;

    // Pop is combinational so the show-ahead head word is consumed on the capture edge;
    // both resets suppress it so an aborted or held block never drops a word.
    assign w_fetch   = (r_state == S_IDLE) & tx_en & ~fifo_empty & sclr_n & aclr_n;
    assign w_bit_end = (r_cnt == C_CNT_LAST);

    assign fifo_rd_en = w_fetch;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign tx_done    = r_done;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (!sclr_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
            end
            // tx_done is registered, so it is raised one cycle ahead to land on the final STOP cycle.
            if ((r_state == S_STOP) && (r_idx == C_STOP_LAST) && (r_cnt == C_CNT_PRE)) begin
                r_done <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fetch) begin
                        r_state  <= S_START;
                        r_shift  <= fifo_dout;
                        r_parity <= (^fifo_dout) ^ C_ODD;
                        r_txd    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == C_DATA_LAST) begin
                            r_idx <= '0;
                            if (C_PAR_EN) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_idx == C_STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
